// File: rtl/imem_fetch.sv
// Instruction memory with a boot-load port and a single registered fetch result.
// Define IMEM_PRELOAD_EN to start from a built-in program in RUN instead of BOOT.
module imem_fetch #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       addr,
    output logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] inst,
    output logic              err,
    input  logic              inst_ack,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    output logic              booted
);

    typedef enum logic {BOOT, RUN} state_t;

`ifdef IMEM_PRELOAD_EN
    localparam state_t RESET_STATE = RUN;
`else
    localparam state_t RESET_STATE = BOOT;
`endif

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] wordIdx;
    logic              addrErr;
    logic              accept;
    logic [DATA_W-1:0] memWord;

    assign wordIdx = addr[ADDR_W+1:2];
    assign addrErr = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);

`ifdef IMEM_PRELOAD_EN
    // The preloaded image never returns to BOOT, so it can never be rewritten: a ROM suffices.
    logic unusedLoad;
    assign unusedLoad = ^{ld_en, ld_addr, ld_data};

    always_comb begin
        memWord = '0;
        case (32'(wordIdx))
            32'd0:   memWord = DATA_W'(32'h20010008);
            32'd1:   memWord = DATA_W'(32'h3402000c);
            32'd2:   memWord = DATA_W'(32'h00411822);
            32'd3:   memWord = DATA_W'(32'h2004000a);
            32'd4:   memWord = DATA_W'(32'h00442825);
            32'd5:   memWord = DATA_W'(32'h00443024);
            32'd6:   memWord = DATA_W'(32'h00223820);
            32'd7:   memWord = DATA_W'(32'h08000009);
            32'd8:   memWord = DATA_W'(32'h14220001);
            32'd9:   memWord = DATA_W'(32'h1026fffe);
            32'd10:  memWord = DATA_W'(32'hac03000c);
            32'd11:  memWord = DATA_W'(32'h8c04000c);
            32'd12:  memWord = DATA_W'(32'h3048000a);
            default: memWord = '0;
        endcase
    end
`else
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Memory is deliberately not reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (state_q == BOOT && ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    assign memWord = mem_q[wordIdx];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            inst_q  <= inst_d;
        end
    end

    assign ready  = (state_q == RUN) && (!valid_q || inst_ack);
    assign accept = req && ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        err_d   = err_q;
        inst_d  = inst_q;
        if (state_q == BOOT && ld_done) begin
            state_d = RUN;
        end
        if (accept) begin
            valid_d = 1'b1;
            err_d   = addrErr;
            inst_d  = addrErr ? '0 : memWord;
        end else if (valid_q && inst_ack) begin
            valid_d = 1'b0;
        end
    end

    assign valid  = valid_q;
    assign err    = err_q;
    assign inst   = inst_q;
    assign booted = (state_q == RUN);

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: a spec-level model checked every cycle plus literal expectations.
// Works with or without IMEM_PRELOAD_EN defined.
module tb_imem_fetch;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;
`ifdef IMEM_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic [31:0]       addr = '0;
    logic              ready;
    logic              valid;
    logic [DATA_W-1:0] inst;
    logic              err;
    logic              inst_ack = 1'b0;
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_done = 1'b0;
    logic              booted;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [13] = '{32'h20010008, 32'h3402000c, 32'h00411822, 32'h2004000a,
                               32'h00442825, 32'h00443024, 32'h00223820, 32'h08000009,
                               32'h14220001, 32'h1026fffe, 32'hac03000c, 32'h8c04000c,
                               32'h3048000a};

    imem_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .ready(ready), .valid(valid),
        .inst(inst), .err(err), .inst_ack(inst_ack), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_done(ld_done), .booted(booted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic reqV, input logic [31:0] addrV, input logic ackV);
        req      = reqV;
        addr     = addrV;
        inst_ack = ackV;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: memory array plus one result slot, updated from the rules at each edge.
    logic [31:0] mMem [DEPTH];
    bit          mKnownWord [DEPTH];
    bit          mStarted = 1'b0;
    bit          mBooted = 1'b0;
    bit          mValid = 1'b0;
    bit          mErr = 1'b0;
    bit          mKnown = 1'b0;
    logic [31:0] mInst = '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mMem[i]       = (PRELOAD && i < 13) ? prog[i] : 32'h0;
            mKnownWord[i] = PRELOAD;
        end
    end

    always @(posedge clk) begin
        bit fire;
        bit bad;
        int idx;
        if (rst) begin
            mStarted = 1'b1;
            mBooted  = PRELOAD;
            mValid   = 1'b0;
            mErr     = 1'b0;
            mInst    = '0;
        end else if (mStarted) begin
            fire = req && mBooted && (!mValid || inst_ack);
            if (!mBooted) begin
                if (ld_en) begin
                    mMem[int'(ld_addr)]       = ld_data;
                    mKnownWord[int'(ld_addr)] = 1'b1;
                end
                if (ld_done) mBooted = 1'b1;
            end
            if (fire) begin
                bad    = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
                idx    = bad ? 0 : int'(addr / 4);
                mValid = 1'b1;
                mErr   = bad;
                mInst  = bad ? 32'h0 : mMem[idx];
                mKnown = bad || mKnownWord[idx];
            end else if (mValid && inst_ack) begin
                mValid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mStarted) begin
            checkOutput("model.valid", 32'(valid), 32'(mValid));
            checkOutput("model.booted", 32'(booted), 32'(mBooted));
            checkOutput("model.ready", 32'(ready), 32'(mBooted && (!mValid || inst_ack)));
            if (mValid) begin
                checkOutput("model.err", 32'(err), 32'(mErr));
                if (mKnown) checkOutput("model.inst", inst, mInst);
            end
        end
    end

    initial begin
        logic [31:0] word3;
        word3 = PRELOAD ? 32'h2004000a : 32'hDEADBEEF;

        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset.valid", 32'(valid), 32'h0);
        checkOutput("reset.inst", inst, 32'h0);
        checkOutput("reset.booted", 32'(booted), 32'(PRELOAD));

        applyStimulus(1'b1, 32'h8, 1'b1);
        #1;
        checkOutput("boot.ready", 32'(ready), 32'(PRELOAD));
        tick();
        checkOutput("boot.noFetch", 32'(valid), 32'(PRELOAD));

        applyStimulus(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 13; i++) begin
            ld_en = 1'b1; ld_addr = ADDR_W'(i); ld_data = prog[i];
            tick();
        end
        ld_addr = ADDR_W'(31); ld_data = 32'hCAFEF00D;
        tick();
        ld_addr = ADDR_W'(3); ld_data = 32'hDEADBEEF; ld_done = 1'b1;
        tick();
        ld_en = 1'b0; ld_done = 1'b0;
        checkOutput("load.booted", 32'(booted), 32'h1);

        // Load strobes in RUN must not disturb word 0.
        ld_en = 1'b1; ld_addr = '0; ld_data = 32'h11111111; ld_done = 1'b1;
        applyStimulus(1'b1, 32'h8, 1'b1);
        tick();
        ld_en = 1'b0; ld_done = 1'b0;
        checkOutput("fetch8.valid", 32'(valid), 32'h1);
        checkOutput("fetch8.inst", inst, 32'h00411822);
        checkOutput("fetch8.err", 32'(err), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("ackClear.valid", 32'(valid), 32'h0);

        applyStimulus(1'b1, 32'h0, 1'b1);
        tick();
        checkOutput("burst0.inst", inst, 32'h20010008);
        applyStimulus(1'b1, 32'h4, 1'b1);
        tick();
        checkOutput("burst1.inst", inst, 32'h3402000c);
        applyStimulus(1'b1, 32'h1C, 1'b1);
        tick();
        checkOutput("burst2.valid", 32'(valid), 32'h1);
        checkOutput("burst2.inst", inst, 32'h08000009);

        applyStimulus(1'b1, 32'h6, 1'b1);
        tick();
        checkOutput("mis.err", 32'(err), 32'h1);
        checkOutput("mis.inst", inst, 32'h0);
        applyStimulus(1'b1, 32'h80, 1'b1);
        tick();
        checkOutput("range.err", 32'(err), 32'h1);
        checkOutput("range.inst", inst, 32'h0);
        applyStimulus(1'b1, 32'h7C, 1'b1);
        tick();
        checkOutput("top.err", 32'(err), 32'h0);
        applyStimulus(1'b1, 32'hFFFFFFFC, 1'b1);
        tick();
        checkOutput("high.err", 32'(err), 32'h1);

        applyStimulus(1'b1, 32'h30, 1'b1);
        tick();
        checkOutput("hold.first", inst, 32'h3048000a);
        applyStimulus(1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("hold.ready", 32'(ready), 32'h0);
            tick();
            checkOutput("hold.inst", inst, 32'h3048000a);
            checkOutput("hold.valid", 32'(valid), 32'h1);
        end
        applyStimulus(1'b1, 32'hC, 1'b1);
        #1;
        checkOutput("release.ready", 32'(ready), 32'h1);
        tick();
        checkOutput("word3.inst", inst, word3);

        applyStimulus(1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstDrop.valid", 32'(valid), 32'h0);
        checkOutput("rstDrop.booted", 32'(booted), 32'(PRELOAD));
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        applyStimulus(1'b1, 32'hC, 1'b1);
        tick();
        checkOutput("keep.inst", inst, word3);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
